load_exec_ctrl: RTL and testbench

LOAD_EXEC_CTRL -- requirements
Module: load_exec_ctrl

---
 rtl/load_exec_ctrl_pkg.sv | 16 +
 rtl/load_exec_ctrl_if.sv | 27 ++
 rtl/load_exec_ctrl_budget.sv | 34 +++
 rtl/load_exec_ctrl.sv | 153 +++++++++++++++
 tb/tb_load_exec_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_exec_ctrl_pkg.sv
// rtl/load_exec_ctrl_pkg.sv - shared state encoding and width defaults for the load/execute controller
package proc_ctrl_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ARM   = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/load_exec_ctrl_if.sv
// rtl/load_exec_ctrl_if.sv - program load stream and instruction-memory write port
interface load_exec_ctrl_if
    import proc_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_a, mem_d
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_a, mem_d
    );

endinterface

// File: rtl/load_exec_ctrl_budget.sv
// rtl/load_exec_ctrl_budget.sv - 16-bit loadable run-budget down-counter with expiry flag
module cycle_budget_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic        expired
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // A zero budget never decrements, so it can never expire.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 16'd0)) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == 16'd1);

endmodule

// File: rtl/load_exec_ctrl.sv
// rtl/load_exec_ctrl.sv - loads a program into instruction memory, then runs or steps the processor
module load_exec_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CLR_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_load,
    input  logic                abort,
    input  logic                run_go,
    input  logic                step,
    input  logic [15:0]         cycle_limit,
    input  logic                halt_in,
    load_exec_ctrl_if.slave     bus,
    output logic                proc_rst,
    output logic                exec,
    output logic [2:0]          state_o,
    output logic [ADDR_W:0]     load_count,
    output logic                done,
    output logic                err_ovf
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST  = CLR_W'(CLR_CYCLES - 1);
    localparam logic [ADDR_W:0]  LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

    state_t            state_q, state_d;
    logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              err_ovf_q, err_ovf_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [DATA_W-1:0] mem_d_q, mem_d_d;
    logic              step_q, step_d;
    logic              in_ready;
    logic              xfer;
    logic              budget_load;
    logic              budget_expired;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        load_count_d = load_count_q;
        err_ovf_d    = err_ovf_q;
        mem_a_d      = mem_a_q;
        mem_d_d      = mem_d_q;
        step_d       = 1'b0;
        budget_load  = 1'b0;
        // Abort masks the handshake so no word slips into memory on the abort cycle.
        in_ready     = (state_q == ST_LOAD) && !abort;
        xfer         = bus.in_valid && in_ready;
        mem_we_d     = xfer;

        if (xfer) begin
            mem_a_d      = load_count_q[ADDR_W-1:0];
            mem_d_d      = bus.in_data;
            load_count_d = load_count_q + (ADDR_W+1)'(1);
        end

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_load) begin
                        state_d      = ST_CLEAR;
                        clr_cnt_d    = '0;
                        load_count_d = '0;
                        err_ovf_d    = 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_d = ST_LOAD;
                    end else begin
                        clr_cnt_d = clr_cnt_q + CLR_W'(1);
                    end
                end
                ST_LOAD: begin
                    // Leaving LOAD on the final slot keeps the write address from wrapping.
                    if (xfer) begin
                        if (bus.in_last) begin
                            state_d = ST_ARM;
                        end else if (load_count_q == LAST_SLOT) begin
                            state_d   = ST_ARM;
                            err_ovf_d = 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    if (run_go) begin
                        state_d     = ST_RUN;
                        budget_load = 1'b1;
                    end else if (step) begin
                        step_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (halt_in || budget_expired) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= '0;
            load_count_q <= '0;
            err_ovf_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_a_q      <= '0;
            mem_d_q      <= '0;
            step_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            load_count_q <= load_count_d;
            err_ovf_q    <= err_ovf_d;
            mem_we_q     <= mem_we_d;
            mem_a_q      <= mem_a_d;
            mem_d_q      <= mem_d_d;
            step_q       <= step_d;
        end
    end

    cycle_budget_counter u_budget (
        .clk      (clk),
        .rst      (rst),
        .load     (budget_load),
        .load_val (cycle_limit),
        .dec      (state_q == ST_RUN),
        .expired  (budget_expired)
    );

    assign bus.in_ready = in_ready;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_d    = mem_d_q;
    assign proc_rst     = (state_q == ST_CLEAR);
    assign exec         = (state_q == ST_RUN) || step_q;
    assign done         = (state_q == ST_DONE);
    assign state_o      = state_q;
    assign load_count   = load_count_q;
    assign err_ovf      = err_ovf_q;

endmodule

// File: tb/tb_load_exec_ctrl.sv
// tb/tb_load_exec_ctrl.sv - scoreboard bench for load_exec_ctrl
module tb_load_exec_ctrl;
    import proc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_load = 1'b0;
    logic        abort = 1'b0;
    logic        run_go = 1'b0;
    logic        step = 1'b0;
    logic [15:0] cycle_limit = 16'd0;
    logic        halt_in = 1'b0;
    logic        proc_rst, exec, done, err_ovf;
    logic [2:0]  state_o;
    logic [9:0]  load_count;

    load_exec_ctrl_if #(.ADDR_W(9), .DATA_W(32)) bus ();

    load_exec_ctrl #(.ADDR_W(9), .DATA_W(32), .CLR_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_load  (start_load),
        .abort       (abort),
        .run_go      (run_go),
        .step        (step),
        .cycle_limit (cycle_limit),
        .halt_in     (halt_in),
        .bus         (bus),
        .proc_rst    (proc_rst),
        .exec        (exec),
        .state_o     (state_o),
        .load_count  (load_count),
        .done        (done),
        .err_ovf     (err_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0]  a;
        logic [31:0] d;
        int          due;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  passed = 0;
    int  exec_seen = 0;
    int  writes_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        chk(name, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] data, input logic last, inout int addr);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        wait_ready("send_ready");
        exp_q.push_back('{9'(addr), data, cyc + 1});
        addr++;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Monitor: every write must match the oldest expected write, on its due cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (exec) exec_seen++;
            if (bus.mem_we) begin
                writes_seen++;
                chk("we_exec_overlap", 32'(exec), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: got a=0x%0h d=0x%0h expected no write", bus.mem_a, bus.mem_d);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.mem_a), 32'(mon_e.a));
                    chk("wr_data", bus.mem_d, mon_e.d);
                    chk("wr_latency", 32'(cyc), 32'(mon_e.due));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int addr;
        int pr;
        int n;
        int wr0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        bus.in_last  = 1'b0;

        #3;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_exec", 32'(exec), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_proc_rst", 32'(proc_rst), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err_ovf", 32'(err_ovf), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_load_count", 32'(load_count), 32'd0);
        chk("rst_mem_a", 32'(bus.mem_a), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // three-word load
        start_load = 1'b1; tick(); start_load = 1'b0;
        pr = 0;
        while (proc_rst && pr < 20) begin pr++; tick(); end
        chk("clear_cycles", 32'(pr), 32'd2);
        chk("state_load", 32'(state_o), 32'd2);
        addr = 0;
        send_word(32'hA, 1'b0, addr);
        send_word(32'hB, 1'b0, addr);
        send_word(32'hC, 1'b1, addr);
        chk("load3_count", 32'(load_count), 32'd3);
        chk("load3_state", 32'(state_o), 32'd3);
        tick();
        chk("load3_drained", 32'(exp_q.size()), 32'd0);

        // three single steps
        exec_seen = 0;
        repeat (3) begin
            step = 1'b1; tick(); step = 1'b0; tick(); tick();
        end
        chk("step_exec_count", 32'(exec_seen), 32'd3);
        chk("step_state", 32'(state_o), 32'd3);
        start_load = 1'b1; tick(); start_load = 1'b0;
        chk("arm_ignores_start", 32'(state_o), 32'd3);

        // bounded run of 5 cycles
        cycle_limit = 16'd5;
        exec_seen = 0;
        run_go = 1'b1; tick(); run_go = 1'b0;
        n = 0;
        while (!done && n < 40) begin tick(); n++; end
        chk("run5_done", 32'(done), 32'd1);
        chk("run5_exec_count", 32'(exec_seen), 32'd5);
        repeat (3) tick();
        chk("run5_exec_hold", 32'(exec_seen), 32'd5);
        chk("run5_state", 32'(state_o), 32'd5);

        // unbounded run halted on RUN cycle 7
        start_load = 1'b1; tick(); start_load = 1'b0;
        chk("reload_count_clr", 32'(load_count), 32'd0);
        addr = 0;
        send_word(32'h1234, 1'b1, addr);
        chk("reload_state", 32'(state_o), 32'd3);
        cycle_limit = 16'd0;
        exec_seen = 0;
        run_go = 1'b1; tick(); run_go = 1'b0;
        repeat (6) tick();
        halt_in = 1'b1; tick(); halt_in = 1'b0;
        chk("halt_state", 32'(state_o), 32'd5);
        chk("halt_exec_low", 32'(exec), 32'd0);
        repeat (3) tick();
        chk("halt_exec_count", 32'(exec_seen), 32'd7);
        chk("halt_done", 32'(done), 32'd1);

        // overflow: 600 words offered, no in_last
        start_load = 1'b1; tick(); start_load = 1'b0;
        wait_ready("ovf_ready");
        addr = 0;
        wr0 = writes_seen;
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bus.in_data = 32'h1000_0000 + 32'(addr);
            if (bus.in_ready) begin
                exp_q.push_back('{9'(addr), bus.in_data, cyc + 1});
                addr++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        chk("ovf_writes", 32'(writes_seen - wr0), 32'd512);
        chk("ovf_err", 32'(err_ovf), 32'd1);
        chk("ovf_state", 32'(state_o), 32'd3);
        chk("ovf_in_ready", 32'(bus.in_ready), 32'd0);
        chk("ovf_count", 32'(load_count), 32'd512);
        chk("ovf_drained", 32'(exp_q.size()), 32'd0);

        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_arm_state", 32'(state_o), 32'd0);
        chk("abort_keeps_count", 32'(load_count), 32'd512);
        chk("abort_keeps_err", 32'(err_ovf), 32'd1);

        // abort after two words of a load
        start_load = 1'b1; tick(); start_load = 1'b0;
        addr = 0;
        send_word(32'h55, 1'b0, addr);
        send_word(32'h66, 1'b0, addr);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h77;
        abort = 1'b1;
        #1;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        abort = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_load_state", 32'(state_o), 32'd0);
        chk("abort_load_count", 32'(load_count), 32'd2);
        wr0 = writes_seen;
        repeat (3) tick();
        chk("abort_no_write", 32'(writes_seen - wr0), 32'd0);

        // reset in the middle of a run
        start_load = 1'b1; tick(); start_load = 1'b0;
        addr = 0;
        send_word(32'h99, 1'b1, addr);
        cycle_limit = 16'd0;
        run_go = 1'b1; tick(); run_go = 1'b0;
        tick(); tick();
        chk("run_exec_high", 32'(exec), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_exec", 32'(exec), 32'd0);
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_count", 32'(load_count), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("arst_mem_d", bus.mem_d, 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wr0 = writes_seen;
        exec_seen = 0;
        repeat (4) tick();
        chk("post_rst_exec", 32'(exec_seen), 32'd0);
        chk("post_rst_writes", 32'(writes_seen - wr0), 32'd0);
        chk("post_rst_state", 32'(state_o), 32'd0);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
